// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift sequencer: opcodes (the same encoding as
// the shift register ctrl field) and the controller state encoding.
package shift_seq_ctrl_pkg;

    localparam logic [2:0] OP_CLR  = 3'd0;  // q <= 0
    localparam logic [2:0] OP_LOAD = 3'd1;  // q <= data
    localparam logic [2:0] OP_SRL  = 3'd2;  // logical right
    localparam logic [2:0] OP_SLL  = 3'd3;  // logical left
    localparam logic [2:0] OP_SRA  = 3'd4;  // arithmetic right
    localparam logic [2:0] OP_SIN  = 3'd5;  // serial in at MSB
    localparam logic [2:0] OP_ROR  = 3'd6;  // rotate right
    localparam logic [2:0] OP_ROL  = 3'd7;  // rotate left

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_step.sv
// Per-step next-value function of the 8-bit multi-mode shift register.
// Purely combinational.
//   op     : opcode (see package)
//   q      : current register value
//   data   : load value for OP_LOAD
//   sbit   : serial input bit for OP_SIN
//   q_next : register value after one step
module shift_step
    import shift_seq_ctrl_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] q,
    input  logic [7:0] data,
    input  logic       sbit,
    output logic [7:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_CLR:  q_next = 8'h00;
            OP_LOAD: q_next = data;
            OP_SRL:  q_next = {1'b0, q[7:1]};
            OP_SLL:  q_next = {q[6:0], 1'b0};
            OP_SRA:  q_next = {q[7], q[7:1]};
            OP_SIN:  q_next = {sbit, q[7:1]};
            OP_ROR:  q_next = {q[0], q[7:1]};
            OP_ROL:  q_next = {q[6:0], q[7]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer around the 8-bit multi-mode shift register.
// Accepts one command (op, step count, data) per valid/ready handshake,
// applies the op for the requested number of cycles, then pulses done.
//   clk, rst   : clock, synchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : command can be accepted (IDLE only)
//   cmd_op     : opcode
//   cmd_cnt    : step count for ops 2-7 (ops 0/1 always take one step)
//   cmd_data   : load value (op 1) or serial bit source (op 5)
//   busy       : command in progress
//   done       : one-cycle completion pulse
//   q          : register value
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | one step applied per clock until remain reaches zero
// DONE  | completion cycle, done high, returns to IDLE
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [7:0]       cmd_data,
    output logic             busy,
    output logic             done,
    output logic [7:0]       q
);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] remain_q, remain_nxt;
    logic [2:0]       bit_idx_q, bit_idx_nxt;
    logic [2:0]       op_q, op_nxt;
    logic [7:0]       data_q, data_nxt;
    logic [7:0]       q_q, q_nxt;
    logic [7:0]       step_q;
    logic             done_q;

    shift_step u_step (
        .op     (op_q),
        .q      (q_q),
        .data   (data_q),
        .sbit   (data_q[bit_idx_q]),
        .q_next (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            bit_idx_q <= 3'd0;
            op_q      <= OP_CLR;
            data_q    <= 8'h00;
            q_q       <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            remain_q  <= remain_nxt;
            bit_idx_q <= bit_idx_nxt;
            op_q      <= op_nxt;
            data_q    <= data_nxt;
            q_q       <= q_nxt;
            // done tracks entry into DONE so it comes straight from a flop
            done_q    <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt   = state_q;
        remain_nxt  = remain_q;
        bit_idx_nxt = bit_idx_q;
        op_nxt      = op_q;
        data_nxt    = data_q;
        q_nxt       = q_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_nxt      = cmd_op;
                    data_nxt    = cmd_data;
                    bit_idx_nxt = 3'd0;
                    if (cmd_op == OP_CLR || cmd_op == OP_LOAD) begin
                        remain_nxt = CNT_W'(1);
                        state_nxt  = RUN;
                    end else if (cmd_cnt != '0) begin
                        remain_nxt = cmd_cnt;
                        state_nxt  = RUN;
                    end else begin
                        // zero-step shift: complete without touching q
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                q_nxt       = step_q;
                remain_nxt  = remain_q - CNT_W'(1);
                bit_idx_nxt = bit_idx_q + 3'd1;
                if (remain_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign q         = q_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_cnt = 4'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] q;

    int errors = 0;
    int checks = 0;
    int mq = 0;   // reference register value

    shift_seq_ctrl #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .q         (q)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One step of the reference register, written as byte arithmetic.
    function automatic int ref_step(int op, int v, int data, int idx);
        int bit_in;
        bit_in = (data >> idx) % 2;
        case (op)
            0: return 0;
            1: return data % 256;
            2: return v / 2;
            3: return (v * 2) % 256;
            4: return v / 2 + (v / 128) * 128;
            5: return v / 2 + bit_in * 128;
            6: return v / 2 + (v % 2) * 128;
            default: return (v * 2) % 256 + v / 128;
        endcase
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Issue one command from IDLE and follow it to the cycle after done.
    task automatic run_cmd(int op, int cnt, int data);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op[2:0];
        cmd_cnt   = cnt[3:0];
        cmd_data  = data[7:0];
        chk("ready_before_accept", int'(cmd_ready), 1);
        cycle();
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_cnt   = 4'($urandom);
        cmd_data  = 8'($urandom);
        n = (op <= 1) ? 1 : cnt;
        if (n == 0) begin
            chk("zero_cnt_done", int'(done), 1);
            chk("zero_cnt_busy", int'(busy), 1);
            chk("zero_cnt_q", int'(q), mq);
        end else begin
            chk("accept_busy", int'(busy), 1);
            chk("accept_done", int'(done), 0);
            chk("accept_q", int'(q), mq);
            for (int k = 0; k < n; k++) begin
                cycle();
                mq = ref_step(op, mq, data, k % 8);
                chk("step_q", int'(q), mq);
                chk("step_done", int'(done), (k == n - 1) ? 1 : 0);
                chk("step_ready", int'(cmd_ready), 0);
            end
        end
        cycle();
        chk("post_done", int'(done), 0);
        chk("post_ready", int'(cmd_ready), 1);
        chk("post_busy", int'(busy), 0);
        chk("post_q", int'(q), mq);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        mq = 0;
        chk("reset_q", int'(q), 0);
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
    endtask

    task automatic test_load_shift();
        run_cmd(1, 0, 8'hA5);
        chk("load_a5", int'(q), 8'hA5);
        run_cmd(2, 3, 8'h00);
        chk("srl3", int'(q), 8'h14);
        run_cmd(1, 5, 8'h96);
        run_cmd(4, 2, 8'h00);
        chk("sra2", int'(q), 8'hE5);
        run_cmd(3, 1, 8'h00);
        chk("sll1", int'(q), 8'hCA);
        run_cmd(0, 7, 8'h33);
        chk("clr", int'(q), 8'h00);
    endtask

    task automatic test_rotate();
        run_cmd(1, 0, 8'h81);
        run_cmd(7, 9, 8'h00);
        chk("rol9", int'(q), 8'h03);
        run_cmd(6, 0, 8'h00);
        chk("ror0", int'(q), 8'h03);
        run_cmd(6, 8, 8'h00);
        chk("ror8", int'(q), 8'h03);
    endtask

    task automatic test_serial();
        run_cmd(0, 0, 8'h00);
        run_cmd(5, 8, 8'h3C);
        chk("sin8", int'(q), 8'h3C);
        run_cmd(0, 0, 8'h00);
        run_cmd(5, 15, 8'h01);
        chk("sin15_wrap", int'(q), 8'h02);
    endtask

    task automatic test_busy_ignore();
        run_cmd(1, 0, 8'hC3);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_cnt   = 4'd10;
        cmd_data  = 8'h00;
        cycle();
        cmd_op   = 3'd1;
        cmd_data = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            cycle();
            mq = ref_step(2, mq, 0, k % 8);
            chk("busy_step_q", int'(q), mq);
            chk("busy_ready", int'(cmd_ready), 0);
        end
        chk("busy_done", int'(done), 1);
        cycle();
        chk("idle_ready", int'(cmd_ready), 1);
        chk("idle_q", int'(q), mq);
        cycle();
        cmd_valid = 1'b0;
        chk("late_accept_busy", int'(busy), 1);
        chk("late_accept_q", int'(q), mq);
        cycle();
        mq = 8'hFF;
        chk("late_load_q", int'(q), 8'hFF);
        chk("late_load_done", int'(done), 1);
        cycle();
        chk("late_idle", int'(cmd_ready), 1);
    endtask

    task automatic test_reset_abort();
        run_cmd(1, 0, 8'h4D);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_cnt   = 4'd10;
        cmd_data  = 8'h00;
        cycle();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            mq = ref_step(7, mq, 0, k);
            chk("abort_step_q", int'(q), mq);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        mq = 0;
        chk("abort_q", int'(q), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        run_cmd(1, 0, 8'h5A);
        chk("after_abort_q", int'(q), 8'h5A);
    endtask

    task automatic test_random();
        int op, cnt, data, gap;
        for (int i = 0; i < 40; i++) begin
            op   = $urandom_range(0, 7);
            cnt  = $urandom_range(0, 15);
            data = $urandom_range(0, 255);
            run_cmd(op, cnt, data);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cycle();
                chk("gap_hold_q", int'(q), mq);
                chk("gap_done", int'(done), 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_rotate();
        test_serial();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
